data_bus_responder: RTL and testbench
=====================================

# data_bus_responder

Memory-mapped responder on the processor's data port: serves `ReadData`/`WriteData` requests, drives `DataIn` and `DataWaitreq`, and inserts wait states for the synchronous data RAM. It decodes `DataAddr` into the RAM and the board I/O (LEDR, HEX displays, SW, KEY). It sits between `processor` and the data-memory instance, replacing the direct RAM hookup with zero-wait tie-offs.

## Interface
- `RAM_LATENCY`, default 1: clock edges from the RAM sampling its address to `RamQ` being valid, range 1–7.
- `Clock` in 1: single system clock, all state on the rising edge.
- `Reset` in 1: synchronous, active-low; `Reset`=0 at a rising edge resets the block.
- `DataAddr` in 16: request address.
- `DataOut` in 16: write data from the processor.
- `WriteData` in 1: write request.
- `ReadData` in 1: read request.
- `DataIn` out 16: read data to the processor.
- `DataWaitreq` out 1: stall; the request is not complete while this is 1.
- `RamAddr` out 12: RAM address.
- `RamWrData` out 16: RAM write data.
- `RamWren` out 1: RAM write enable.
- `RamQ` in 16: RAM read data.
- `SW` in 10 and `KEY` in 4: asynchronous board inputs.
- `LEDR` out 10: LED register.
- `HEX0`–`HEX5` out 7 each: segment registers, active-low segments.

## Operation
- Protocol:
  - A request completes in any cycle where (`ReadData` or `WriteData`) = 1 and `DataWaitreq` = 0.
  - The processor holds `DataAddr`, `DataOut` and the request stable while `DataWaitreq` = 1.
- Decode on `DataAddr[15:12]`:
  - 0x0: RAM at `[11:0]`.
  - 0x1: LEDR, read/write, `[9:0]`.
  - 0x2: HEX bank, `DataAddr[2:0]` 0–5 selects HEX0–HEX5, `[6:0]`; 6–7 read 0 and ignore writes.
  - 0x3: SW, read-only.
  - 0x4: KEY, read-only, raw active-low.
  - All other values: read 0, writes ignored.
- Read data is zero-extended.
- Writes to any region complete with zero wait states.
  - `RamWren` = `WriteData` and RAM-selected, combinationally in the request cycle.
  - I/O registers update at that rising edge.
- Reads outside RAM are zero-wait: `DataIn` is a combinational mux of the I/O registers.
- RAM read FSM:
  - IDLE: a RAM read with no write drives `DataWaitreq`=1, latches the address, loads the counter with `RAM_LATENCY`-1, and goes to WAIT.
  - WAIT: `DataWaitreq`=1 while the counter is nonzero; the counter decrements each cycle.
  - At counter 0 the cycle is the completion cycle: `DataWaitreq`=0, `DataIn`=`RamQ`, next state IDLE.
- `RamAddr`: combinational `DataAddr[11:0]` in IDLE; the latched address in WAIT.
- `SW` and `KEY` pass through 2-flop synchronizers before any read.
- Boundary rules:
  - `ReadData` and `WriteData` both 1: treated as a write; `DataIn`=0, no wait.
  - Request drops during WAIT: abort to IDLE next cycle with no side effects.
  - Back-to-back RAM reads: every read re-enters WAIT from IDLE; there is no read pipelining.
  - Reset during WAIT: IDLE at that edge, and `DataWaitreq`=0 from the next cycle.
  - Address change during WAIT is a protocol violation; the latched address is used.

## Timing
- Reset values:
  - `LEDR`=0, `HEX0`–`HEX5`=7'h7F (blank), synchronizers 0, FSM IDLE, counter 0.
  - `DataWaitreq`=0 and `DataIn`=0 while no request is active.
- `DataWaitreq` is combinational from request, decode and state.
- RAM read latency: `RAM_LATENCY` stall cycles, completion in cycle `RAM_LATENCY` after the request cycle.
- I/O read and all writes: completion in the request cycle.
- I/O register writes are visible on the outputs one cycle after the completing edge.
- SW/KEY changes are visible to reads 2 cycles after the input changes.

## Test plan
- LEDR write then read:
  - Stimulus: after reset, write 0x1000 ← 0x03A5.
  - Required: `DataWaitreq`=0, `LEDR`=10'h3A5 next cycle, read of 0x1000 returns 0x03A5 with no stall.
- RAM write then read:
  - Stimulus: with `RAM_LATENCY`=1, write 0x0012 ← 0xBEEF.
  - Required: `RamWren`=1 in the request cycle; the subsequent read stalls exactly 1 cycle and returns 0xBEEF.
- Long latency:
  - Stimulus: `RAM_LATENCY`=3, reads of 0x0001 then 0x0002 back-to-back.
  - Required: each read has exactly 3 `DataWaitreq` cycles and returns the correct word; `RamAddr` is held during WAIT.
- HEX and unmapped regions:
  - Stimulus: write 0x2003 ← 0x0040; read 0x2007; read 0x9000.
  - Required: `HEX3`=7'h40, other HEX outputs stay 7'h7F, both reads return 0.
- Reset during WAIT:
  - Stimulus: `RAM_LATENCY`=4; assert `Reset`=0 in the 2nd WAIT cycle.
  - Required: FSM IDLE, `DataWaitreq`=0, `LEDR`=0 and `HEX`=7'h7F after the edge.
- Inputs and conflicting request:
  - Stimulus: `SW`=10'h155; read 0x3000 three cycles later; then request read+write to 0x1000 ← 0x0007.
  - Required: SW read returns 0x0155; the conflicting request performs the write with `DataIn`=0 and no stall.

Source files
------------

// File: rtl/data_bus_responder.sv
// Memory-mapped responder for the processor data port: decodes RAM and board I/O,
// and inserts RAM_LATENCY wait states on RAM reads.
module data_bus_responder #(
    parameter int RAM_LATENCY = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] DataAddr,
    input  logic [15:0] DataOut,
    input  logic        WriteData,
    input  logic        ReadData,
    output logic [15:0] DataIn,
    output logic        DataWaitreq,
    output logic [11:0] RamAddr,
    output logic [15:0] RamWrData,
    output logic        RamWren,
    input  logic [15:0] RamQ,
    input  logic [9:0]  SW,
    input  logic [3:0]  KEY,
    output logic [9:0]  LEDR,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [2:0] CNT_LOAD = 3'(RAM_LATENCY - 1);

    state_t      state, state_next;
    logic [2:0]  cnt, cnt_next;
    logic [11:0] addr_q;
    logic [9:0]  ledr_q;
    logic [6:0]  hex_q [6];
    logic [9:0]  sw_meta, sw_sync;
    logic [3:0]  key_meta, key_sync;
    logic [6:0]  hex_rd;

    logic [3:0] region;
    logic       rd_only, ram_sel, io_we;

    // A simultaneous read+write is a write, so only a pure read can stall.
    assign region  = DataAddr[15:12];
    assign rd_only = ReadData & ~WriteData;
    assign ram_sel = (region == 4'h0);
    assign io_we   = WriteData & (state == S_IDLE);

    assign RamAddr   = (state == S_WAIT) ? addr_q : DataAddr[11:0];
    assign RamWrData = DataOut;
    assign RamWren   = io_we & ram_sel;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_next  = state;
        cnt_next    = cnt;
        DataWaitreq = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (rd_only && ram_sel) begin
                    DataWaitreq = 1'b1;
                    cnt_next    = CNT_LOAD;
                    state_next  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!rd_only) begin
                    cnt_next   = 3'd0;
                    state_next = S_IDLE;
                end else if (cnt != 3'd0) begin
                    DataWaitreq = 1'b1;
                    cnt_next    = cnt - 3'd1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        hex_rd = '0;
        case (DataAddr[2:0])
            3'd0: hex_rd = hex_q[0];
            3'd1: hex_rd = hex_q[1];
            3'd2: hex_rd = hex_q[2];
            3'd3: hex_rd = hex_q[3];
            3'd4: hex_rd = hex_q[4];
            3'd5: hex_rd = hex_q[5];
            default: hex_rd = '0;
        endcase
    end

    always_comb begin
        DataIn = '0;
        if (rd_only) begin
            if (state == S_WAIT) begin
                if (cnt == 3'd0) DataIn = RamQ;
            end else begin
                case (region)
                    4'h1: DataIn = {6'd0, ledr_q};
                    4'h2: DataIn = {9'd0, hex_rd};
                    4'h3: DataIn = {6'd0, sw_sync};
                    4'h4: DataIn = {12'd0, key_sync};
                    default: DataIn = '0;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state    <= S_IDLE;
            cnt      <= 3'd0;
            ledr_q   <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
            key_meta <= '0;
            key_sync <= '0;
            for (int i = 0; i < 6; i++) hex_q[i] <= 7'h7F;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            sw_meta  <= SW;
            sw_sync  <= sw_meta;
            key_meta <= KEY;
            key_sync <= key_meta;
            if (io_we && region == 4'h1) ledr_q <= DataOut[9:0];
            for (int i = 0; i < 6; i++) begin
                if (io_we && region == 4'h2 && DataAddr[2:0] == 3'(i)) hex_q[i] <= DataOut[6:0];
            end
        end
    end

    // NOTE: the address latch is pure datapath, only consumed in WAIT, so it carries no reset.
    always_ff @(posedge Clock) begin
        if (state == S_IDLE) addr_q <= DataAddr[11:0];
    end

    assign LEDR = ledr_q;
    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: three instances (latency 1, 3, 4), each with its own RAM
// model, driven by directed and random requests and compared against a behavioural model.
module tb_data_bus_responder;

    localparam int ND = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n   [ND];
    logic [15:0] addr    [ND];
    logic [15:0] dout    [ND];
    logic        wr      [ND];
    logic        rd      [ND];
    logic [15:0] din     [ND];
    logic        waitreq [ND];
    logic [11:0] ramaddr [ND];
    logic [15:0] ramwd   [ND];
    logic        ramwren [ND];
    logic [15:0] ramq    [ND];
    logic [9:0]  sw      [ND];
    logic [3:0]  key     [ND];
    logic [9:0]  ledr    [ND];
    logic [6:0]  hex     [ND][6];

    function automatic logic [15:0] init_word(input logic [11:0] a);
        return {a[3:0], a} ^ 16'h3C5A;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
    endfunction

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        logic [15:0] ram   [4096];
        logic [15:0] qpipe [LAT];

        data_bus_responder #(.RAM_LATENCY(LAT)) dut (
            .Clock(clk), .Reset(rst_n[g]), .DataAddr(addr[g]), .DataOut(dout[g]),
            .WriteData(wr[g]), .ReadData(rd[g]), .DataIn(din[g]), .DataWaitreq(waitreq[g]),
            .RamAddr(ramaddr[g]), .RamWrData(ramwd[g]), .RamWren(ramwren[g]), .RamQ(ramq[g]),
            .SW(sw[g]), .KEY(key[g]), .LEDR(ledr[g]),
            .HEX0(hex[g][0]), .HEX1(hex[g][1]), .HEX2(hex[g][2]),
            .HEX3(hex[g][3]), .HEX4(hex[g][4]), .HEX5(hex[g][5])
        );

        initial for (int i = 0; i < 4096; i++) ram[i] = init_word(12'(i));

        always @(posedge clk) begin
            if (ramwren[g]) ram[ramaddr[g]] <= ramwd[g];
            qpipe[0] <= ram[ramaddr[g]];
            for (int k = 1; k < LAT; k++) qpipe[k] <= qpipe[k-1];
        end
        assign ramq[g] = qpipe[LAT-1];
    end

    // Behavioural reference state
    logic [15:0] mem_m  [ND][4096];
    logic [9:0]  ledr_m [ND];
    logic [6:0]  hex_m  [ND][6];
    logic [9:0]  sw_m   [ND];
    logic [3:0]  key_m  [ND];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs_dut(input int d);
        return {12'd0, ledr[d], hex[d][0], hex[d][1], hex[d][2], hex[d][3], hex[d][4], hex[d][5]};
    endfunction

    function automatic logic [63:0] outs_model(input int d);
        return {12'd0, ledr_m[d], hex_m[d][0], hex_m[d][1], hex_m[d][2],
                hex_m[d][3], hex_m[d][4], hex_m[d][5]};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issues one request, holds it until DataWaitreq is low, returns observations.
    task automatic do_req(input int d, input bit r, input bit w, input logic [15:0] a,
                          input logic [15:0] wdat, input bit perturb,
                          output logic [15:0] rdata, output int stalls,
                          output bit wren_seen, output bit addr_held);
        bit done = 0;
        rd[d] = r; wr[d] = w; addr[d] = a; dout[d] = wdat;
        stalls = 0; wren_seen = 0; addr_held = 1; rdata = '0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (c == 0) wren_seen = ramwren[d];
            if (waitreq[d] === 1'b0) begin
                rdata = din[d];
                done  = 1;
            end else begin
                stalls++;
                if (ramaddr[d] !== a[11:0]) addr_held = 0;
            end
            @(posedge clk);
            #1;
            if (!done && perturb) addr[d] = {a[15:12], a[11:0] ^ 12'h0F0};
        end
        rd[d] = 1'b0;
        wr[d] = 1'b0;
    endtask

    task automatic model_op(input int d, input bit r, input bit w, input logic [15:0] a,
                            input logic [15:0] wd, input bit perturb, input string tag);
        logic [15:0] exp_d, got_d;
        int          exp_s, got_s;
        bit          wren_seen, held;
        logic [3:0]  region;
        region = a[15:12];
        exp_s  = 0;
        exp_d  = '0;
        if (r && !w) begin
            case (region)
                4'h0: begin exp_s = lat_of(d); exp_d = mem_m[d][a[11:0]]; end
                4'h1: exp_d = {6'd0, ledr_m[d]};
                4'h2: exp_d = (a[2:0] < 3'd6) ? {9'd0, hex_m[d][a[2:0]]} : 16'd0;
                4'h3: exp_d = {6'd0, sw_m[d]};
                4'h4: exp_d = {12'd0, key_m[d]};
                default: exp_d = '0;
            endcase
        end
        do_req(d, r, w, a, wd, perturb, got_d, got_s, wren_seen, held);
        check({tag, ".wait"}, 64'(got_s), 64'(exp_s));
        check({tag, ".data"}, 64'(got_d), 64'(exp_d));
        if (exp_s > 1) check({tag, ".ramaddr_held"}, 64'(held), 64'd1);
        if (w) begin
            check({tag, ".wren"}, 64'(wren_seen), 64'(region == 4'h0));
            case (region)
                4'h0: mem_m[d][a[11:0]] = wd;
                4'h1: ledr_m[d] = wd[9:0];
                4'h2: if (a[2:0] < 3'd6) hex_m[d][a[2:0]] = wd[6:0];
                default: ;
            endcase
            check({tag, ".outs"}, outs_dut(d), outs_model(d));
        end
    endtask

    task automatic random_ops(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            int          kind, rw;
            logic [15:0] a, wd;
            bit          r, w;
            kind = $urandom_range(0, 9);
            rw   = $urandom_range(0, 3);
            r    = (rw != 2);
            w    = (rw >= 2);
            wd   = 16'($urandom);
            case (kind)
                0, 1, 2: a = {12'h000, 4'($urandom)};
                3:       a = {4'h1, 12'($urandom)};
                4, 5:    a = {4'h2, 12'($urandom)};
                6: begin
                    a = {4'h3, 12'($urandom)};
                    if ($urandom_range(0, 1) == 1) begin
                        sw[d] = 10'($urandom); sw_m[d] = sw[d]; tick(2);
                    end
                end
                7: begin
                    a = {4'h4, 12'($urandom)};
                    if ($urandom_range(0, 1) == 1) begin
                        key[d] = 4'($urandom); key_m[d] = key[d]; tick(2);
                    end
                end
                default: a = {4'($urandom_range(5, 15)), 12'($urandom)};
            endcase
            model_op(d, r, w, a, wd, 1'b0, $sformatf("rnd%0d.%0d", d, i));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < ND; d++) begin
            rst_n[d] = 1'b0; addr[d] = '0; dout[d] = '0; wr[d] = 1'b0; rd[d] = 1'b0;
            sw[d] = '0; key[d] = '0;
            ledr_m[d] = '0; sw_m[d] = '0; key_m[d] = '0;
            for (int h = 0; h < 6; h++) hex_m[d][h] = 7'h7F;
            for (int i = 0; i < 4096; i++) mem_m[d][i] = init_word(12'(i));
        end
        tick(2);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("reset%0d.wait", d), 64'(waitreq[d]), 64'd0);
            check($sformatf("reset%0d.data", d), 64'(din[d]), 64'd0);
            check($sformatf("reset%0d.outs", d), outs_dut(d), outs_model(d));
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) rst_n[d] = 1'b1;
        tick(2);

        // LEDR write then read, RAM write then read (latency 1)
        model_op(0, 1'b0, 1'b1, 16'h1000, 16'h03A5, 1'b0, "ledr_wr");
        model_op(0, 1'b1, 1'b0, 16'h1000, 16'h0000, 1'b0, "ledr_rd");
        model_op(0, 1'b0, 1'b1, 16'h0012, 16'hBEEF, 1'b0, "ram_wr");
        model_op(0, 1'b1, 1'b0, 16'h0012, 16'h0000, 1'b0, "ram_rd");

        // Long latency back-to-back, first with an address wiggle during WAIT
        model_op(1, 1'b1, 1'b0, 16'h0001, 16'h0000, 1'b1, "lat3_rd1");
        model_op(1, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, "lat3_rd2");

        // HEX and unmapped regions
        model_op(0, 1'b0, 1'b1, 16'h2003, 16'h0040, 1'b0, "hex3_wr");
        check("hex3_value", 64'(hex[0][3]), 64'h40);
        model_op(0, 1'b1, 1'b0, 16'h2007, 16'h0000, 1'b0, "hex7_rd");
        model_op(0, 1'b1, 1'b0, 16'h9000, 16'h0000, 1'b0, "unmapped_rd");

        // Request dropped during WAIT aborts without side effects
        rd[1] = 1'b1; addr[1] = 16'h0003;
        tick(1);
        rd[1] = 1'b0;
        @(negedge clk);
        check("abort.wait", 64'(waitreq[1]), 64'd0);
        check("abort.data", 64'(din[1]), 64'd0);
        tick(1);
        model_op(1, 1'b1, 1'b0, 16'h1000, 16'h0000, 1'b0, "abort.io_rd");
        model_op(1, 1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, "abort.ram_rd");

        // Reset in the second WAIT cycle (latency 4)
        model_op(2, 1'b0, 1'b1, 16'h1000, 16'h0155, 1'b0, "rst.ledr_wr");
        model_op(2, 1'b0, 1'b1, 16'h2000, 16'h0012, 1'b0, "rst.hex_wr");
        rd[2] = 1'b1; addr[2] = 16'h0005;
        tick(2);
        rst_n[2] = 1'b0;
        @(negedge clk);
        check("rst.wait_before", 64'(waitreq[2]), 64'd1);
        tick(1);
        rd[2] = 1'b0;
        ledr_m[2] = '0;
        for (int h = 0; h < 6; h++) hex_m[2][h] = 7'h7F;
        @(negedge clk);
        check("rst.wait_after", 64'(waitreq[2]), 64'd0);
        check("rst.outs", outs_dut(2), outs_model(2));
        tick(1);
        rst_n[2] = 1'b1;
        tick(3);
        model_op(2, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, "rst.ram_rd");

        // Synchronized inputs and conflicting request
        sw[0] = 10'h155; sw_m[0] = 10'h155;
        tick(3);
        model_op(0, 1'b1, 1'b0, 16'h3000, 16'h0000, 1'b0, "sw_rd");
        model_op(0, 1'b1, 1'b1, 16'h1000, 16'h0007, 1'b0, "conflict");
        sw[0] = 10'h2AA;
        tick(1);
        model_op(0, 1'b1, 1'b0, 16'h3000, 16'h0000, 1'b0, "sw_rd_early");
        sw_m[0] = 10'h2AA;
        model_op(0, 1'b1, 1'b0, 16'h3000, 16'h0000, 1'b0, "sw_rd_late");
        key[0] = 4'hA; key_m[0] = 4'hA;
        tick(2);
        model_op(0, 1'b1, 1'b0, 16'h4000, 16'h0000, 1'b0, "key_rd");

        for (int d = 0; d < ND; d++) random_ops(d, 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
